// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file.
package csr_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;

  // CSR instruction operation encodings
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpRw   = 2'b01,
    OpRs   = 2'b10,
    OpRc   = 2'b11
  } csr_op_e;

  // mstatus reset value: MPP = M-mode, SXL/UXL = 64-bit
  localparam logic [63:0] MstatusRst = 64'h0000_000A_0000_1800;

  // mstatus field positions
  localparam int unsigned MieBit  = 3;
  localparam int unsigned MpieBit = 7;
  localparam int unsigned MppLo   = 11;
  localparam int unsigned MppHi   = 12;

  // Exception code for environment call from M-mode
  localparam logic [63:0] McauseEcallM = 64'd11;

  typedef enum logic {
    StIdle     = 1'b0,
    StRedirect = 1'b1
  } state_e;

endpackage

// File: rtl/csr_rmw.sv
// Read-modify-write arithmetic for CSR instructions.
module csr_rmw
  import csr_pkg::*;
(
  input  logic [63:0] old_val,
  input  logic [63:0] wdata,
  input  csr_op_e     op,
  output logic [63:0] new_val
);

  // Compute the post-write value for the selected operation
  always_comb begin
    new_val = old_val;
    unique case (op)
      OpRw:    new_val = wdata;
      OpRs:    new_val = old_val | wdata;
      OpRc:    new_val = old_val & ~wdata;
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with ecall/mret trap handling and a one-cycle redirect pulse.
module csr_file
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  output logic [63:0] csr_rdata,
  output logic        illegal,
  input  logic        ecall,
  input  logic [63:0] pc,
  input  logic        mret,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy,
  output logic [63:0] csr_0,
  output logic [63:0] csr_1,
  output logic [63:0] csr_2,
  output logic [63:0] csr_3,
  output logic [63:0] csr_4,
  output logic [63:0] csr_5
);

  logic [63:0] mstatus_q, mstatus_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mtval_q, mtval_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  state_e      state_q, state_d;

  logic        addr_hit;
  logic [63:0] rmw_val;
  logic        in_idle;
  logic        take_ecall;
  logic        take_mret;
  logic        take_csr;

  // Address decode and combinational read of the pre-write value
  always_comb begin
    addr_hit  = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      AddrMstatus:  csr_rdata = mstatus_q;
      AddrMtvec:    csr_rdata = mtvec_q;
      AddrMepc:     csr_rdata = mepc_q;
      AddrMcause:   csr_rdata = mcause_q;
      AddrMscratch: csr_rdata = mscratch_q;
      AddrMtval:    csr_rdata = mtval_q;
      default: begin
        addr_hit  = 1'b0;
        csr_rdata = '0;
      end
    endcase
  end

  assign illegal = csr_valid & ~addr_hit;

  csr_rmw u_rmw (
    .old_val (csr_rdata),
    .wdata   (csr_wdata),
    .op      (csr_op_e'(csr_op)),
    .new_val (rmw_val)
  );

  // Event arbitration: ecall beats mret beats a CSR write; nothing is accepted in REDIRECT
  always_comb begin
    in_idle    = (state_q == StIdle);
    take_ecall = in_idle & ecall;
    take_mret  = in_idle & mret & ~ecall;
    take_csr   = in_idle & csr_valid & (csr_op != OpNone) & addr_hit & ~ecall & ~mret;
  end

  // Next-state values for the CSRs and the latched redirect target
  always_comb begin
    mstatus_d     = mstatus_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mscratch_d    = mscratch_q;
    mtval_d       = mtval_q;
    redirect_pc_d = redirect_pc_q;

    if (take_csr) begin
      case (csr_addr)
        AddrMstatus:  mstatus_d  = rmw_val;
        AddrMtvec:    mtvec_d    = rmw_val & ~64'd3;
        AddrMepc:     mepc_d     = rmw_val & ~64'd1;
        AddrMcause:   mcause_d   = rmw_val;
        AddrMscratch: mscratch_d = rmw_val;
        AddrMtval:    mtval_d    = rmw_val;
        default: ;
      endcase
    end

    if (take_ecall) begin
      mepc_d                 = pc & ~64'd1;
      mcause_d               = McauseEcallM;
      mstatus_d[MpieBit]     = mstatus_q[MieBit];
      mstatus_d[MieBit]      = 1'b0;
      mstatus_d[MppHi:MppLo] = 2'b11;
      redirect_pc_d          = mtvec_q;
    end else if (take_mret) begin
      mstatus_d[MieBit]      = mstatus_q[MpieBit];
      mstatus_d[MpieBit]     = 1'b1;
      mstatus_d[MppHi:MppLo] = 2'b00;
      redirect_pc_d          = mepc_q;
    end
  end

  // CSR and redirect-target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q     <= MstatusRst;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mscratch_q    <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      mstatus_q     <= mstatus_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mscratch_q    <= mscratch_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: REDIRECT lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (take_ecall || take_mret) state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs: the redirect pulse is the REDIRECT state itself
  always_comb begin
    busy           = (state_q == StRedirect);
    redirect_valid = (state_q == StRedirect);
    redirect_pc    = redirect_pc_q;
  end

  assign csr_0 = mstatus_q;
  assign csr_1 = mtvec_q;
  assign csr_2 = mepc_q;
  assign csr_3 = mcause_q;
  assign csr_4 = mscratch_q;
  assign csr_5 = mtval_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
module tb_csr_file;

  logic        clk;
  logic        rst_n;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        illegal;
  logic        ecall;
  logic [63:0] pc;
  logic        mret;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;
  logic [63:0] csr_0, csr_1, csr_2, csr_3, csr_4, csr_5;

  int compared   = 0;
  int mismatched = 0;

  csr_file dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_valid      (csr_valid),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .illegal        (illegal),
    .ecall          (ecall),
    .pc             (pc),
    .mret           (mret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .csr_0          (csr_0),
    .csr_1          (csr_1),
    .csr_2          (csr_2),
    .csr_3          (csr_3),
    .csr_4          (csr_4),
    .csr_5          (csr_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                       input logic [63:0] wd, input logic e, input logic m,
                       input logic [63:0] p);
    csr_valid = v;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = wd;
    ecall     = e;
    mret      = m;
    pc        = p;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 12'h000, 64'h0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;

    // Reset mid-cycle, checked before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check("rst_mstatus", csr_0, 64'h0000_000A_0000_1800);
    check("rst_mtvec", csr_1, 64'h0);
    check("rst_mepc", csr_2, 64'h0);
    check("rst_mcause", csr_3, 64'h0);
    check("rst_mscratch", csr_4, 64'h0);
    check("rst_mtval", csr_5, 64'h0);
    check("rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
    check("rst_redirect_pc", redirect_pc, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // RW / RS / RC on mscratch
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h340, 64'hF0, 1'b0, 1'b0, 64'h0);
    #1;
    check("rw_rdata_prior", csr_rdata, 64'h0);
    check("rw_legal", {63'h0, illegal}, 64'h0);
    tick();
    check("rw_mscratch", csr_4, 64'hF0);
    @(negedge clk);
    drive(1'b1, 2'b10, 12'h340, 64'h0F, 1'b0, 1'b0, 64'h0);
    #1;
    check("rs_rdata_prior", csr_rdata, 64'hF0);
    tick();
    check("rs_mscratch", csr_4, 64'hFF);
    @(negedge clk);
    drive(1'b1, 2'b11, 12'h340, 64'h3C, 1'b0, 1'b0, 64'h0);
    #1;
    check("rc_rdata_prior", csr_rdata, 64'hFF);
    tick();
    check("rc_mscratch", csr_4, 64'hC3);

    // op 00 with csr_valid writes nothing
    @(negedge clk);
    drive(1'b1, 2'b00, 12'h340, 64'hFFFF, 1'b0, 1'b0, 64'h0);
    tick();
    check("nop_mscratch", csr_4, 64'hC3);

    // mtvec low bits and mepc bit 0 forced to zero
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h305, 64'h8000_0007, 1'b0, 1'b0, 64'h0);
    tick();
    check("mtvec_aligned", csr_1, 64'h8000_0004);
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h341, 64'h1235, 1'b0, 1'b0, 64'h0);
    tick();
    check("mepc_aligned", csr_2, 64'h1234);

    // Set MIE so the ecall stacking is visible
    @(negedge clk);
    drive(1'b1, 2'b10, 12'h300, 64'h8, 1'b0, 1'b0, 64'h0);
    tick();
    check("mstatus_mie_set", csr_0, 64'h0000_000A_0000_1808);

    // ecall
    @(negedge clk);
    drive(1'b0, 2'b00, 12'h000, 64'h0, 1'b1, 1'b0, 64'h8000_0100);
    tick();
    check("ecall_redirect_valid", {63'h0, redirect_valid}, 64'h1);
    check("ecall_busy", {63'h0, busy}, 64'h1);
    check("ecall_redirect_pc", redirect_pc, 64'h8000_0004);
    check("ecall_mepc", csr_2, 64'h8000_0100);
    check("ecall_mcause", csr_3, 64'd11);
    check("ecall_mstatus", csr_0, 64'h0000_000A_0000_1880);
    @(negedge clk);
    idle();
    tick();
    check("ecall_pulse_end", {63'h0, redirect_valid}, 64'h0);
    check("ecall_busy_end", {63'h0, busy}, 64'h0);

    // mret, with a concurrent mscratch write that must be dropped
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h340, 64'h55, 1'b0, 1'b1, 64'h0);
    #1;
    check("mret_rdata_driven", csr_rdata, 64'hC3);
    tick();
    check("mret_redirect_valid", {63'h0, redirect_valid}, 64'h1);
    check("mret_redirect_pc", redirect_pc, 64'h8000_0100);
    check("mret_mstatus", csr_0, 64'h0000_000A_0000_0088);
    check("mret_csr_dropped", csr_4, 64'hC3);

    // ecall and a CSR write while busy are ignored
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h340, 64'h77, 1'b1, 1'b0, 64'h9999_0000);
    tick();
    check("busy_ecall_mepc", csr_2, 64'h8000_0100);
    check("busy_ecall_mstatus", csr_0, 64'h0000_000A_0000_0088);
    check("busy_csr_ignored", csr_4, 64'hC3);
    check("busy_no_redirect", {63'h0, redirect_valid}, 64'h0);

    // Clear mcause, then ecall + mret + RW mepc together
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h342, 64'h0, 1'b0, 1'b0, 64'h0);
    tick();
    check("mcause_cleared", csr_3, 64'h0);
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h341, 64'hDEAD_0000, 1'b1, 1'b1, 64'h8000_0200);
    tick();
    check("prio_mepc", csr_2, 64'h8000_0200);
    check("prio_mcause", csr_3, 64'd11);
    check("prio_mstatus", csr_0, 64'h0000_000A_0000_1880);
    check("prio_redirect_pc", redirect_pc, 64'h8000_0004);
    @(negedge clk);
    idle();
    tick();

    // Unimplemented address
    @(negedge clk);
    drive(1'b1, 2'b01, 12'h7C0, 64'hFFFF, 1'b0, 1'b0, 64'h0);
    #1;
    check("illegal_flag", {63'h0, illegal}, 64'h1);
    check("illegal_rdata", csr_rdata, 64'h0);
    tick();
    check("illegal_mstatus", csr_0, 64'h0000_000A_0000_1880);
    check("illegal_mtvec", csr_1, 64'h8000_0004);
    check("illegal_mepc", csr_2, 64'h8000_0200);
    check("illegal_mcause", csr_3, 64'd11);
    check("illegal_mscratch", csr_4, 64'hC3);
    check("illegal_mtval", csr_5, 64'h0);

    // Reset during REDIRECT cancels the pulse
    @(negedge clk);
    drive(1'b0, 2'b00, 12'h000, 64'h0, 1'b1, 1'b0, 64'h10);
    tick();
    check("pre_rst_busy", {63'h0, busy}, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_mepc", csr_2, 64'h0);
    check("mid_rst_mstatus", csr_0, 64'h0000_000A_0000_1800);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {63'h0, busy}, 64'h0);
    check("post_rst_no_pulse", {63'h0, redirect_valid}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
